// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the HI/LO multiply/divide unit.
//   mdu_op_t    - 3-bit operation encoding as issued by the pipeline.
//   mdu_state_t - sequencer states (IDLE, CALC, FIX).
//   cntWidth()  - width of the iteration counter for a given datapath width;
//                 one extra bit so the counter can hold WIDTH without wrapping.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

    function automatic int cntWidth(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic logic isDiv(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // MADD/MSUB accumulate a signed product.
    function automatic logic isSignedOp(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational iteration of a restoring divider.
// The dividend magnitude enters through quo (MSB first); each step shifts one
// dividend bit into the partial remainder and shifts one quotient bit in.
//   rem/quo       - current partial remainder / shifting dividend-quotient word
//   divisor       - divisor magnitude
//   remNext/quoNext - values after this iteration
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // shifted < 2*divisor, so the MSB of the difference is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH]) begin
            remNext = shifted[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b0};
        end else begin
            remNext = diff[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the HI/LO register pair.
// Optional feature macro: MDU_DIV_EN (defined -> DIV/DIVU use the restoring
// divider; undefined -> DIV/DIVU complete in one cycle with no effect).
// Ports:
//   Clk, Rst      - clock, synchronous active-high reset
//   Start, Op     - issue pulse and operation (sampled only when idle)
//   Flush         - squash in-flight op / suppress a same-cycle issue
//   A, B          - rs / rt operands, captured at issue
//   Busy          - high while calculating or fixing up
//   Done, DivZero - one-cycle completion pulse and divide-by-zero flag
//   Hi, Lo        - architectural HI/LO registers
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Flush,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = cntWidth(WIDTH);

    mdu_state_t         state, stateNext;
    mdu_op_t            opIn, opReg;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, accNext, mulNext, prodS;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH-1:0]   operand;   // multiplicand (mult) or divisor (div), magnitude
    logic [WIDTH-1:0]   aMag, bMag, hiNew, loNew;
    logic               negRes, signA, signB, dzNew;
    logic               issue, longOp, issueLong, issueShort;

    assign opIn  = mdu_op_t'(Op);
    assign signA = isSignedOp(opIn) & A[WIDTH-1];
    assign signB = isSignedOp(opIn) & B[WIDTH-1];
    assign aMag  = signA ? -A : A;
    assign bMag  = signB ? -B : B;

`ifdef MDU_DIV_EN
    assign longOp = (opIn != OP_MTHI) && (opIn != OP_MTLO);
`else
    assign longOp = (opIn == OP_MULT) || (opIn == OP_MULTU) ||
                    (opIn == OP_MADD) || (opIn == OP_MSUB);
`endif

    assign issue      = (state == S_IDLE) && Start && !Flush;
    assign issueLong  = issue && longOp;
    assign issueShort = issue && !longOp;

    // ---- FSM: state register ----
    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    // ---- FSM: next state ----
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: if (issueLong) stateNext = S_CALC;
            S_CALC: begin
                if (Flush)                              stateNext = S_IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))      stateNext = S_FIX;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        Busy = (state != S_IDLE);
    end

    // ---- shift-add multiply step: multiplier sits in the low half ----
    always_comb begin
        mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        if (acc[0]) mulNext = {mulSum, acc[WIDTH-1:1]};
        else        mulNext = {1'b0, acc[2*WIDTH-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] remNext, quoNext, aRaw;
    logic             negRem, bZero;

    mdu_div_step #(.WIDTH(WIDTH)) uDivStep (
        .rem     (acc[2*WIDTH-1:WIDTH]),
        .quo     (acc[WIDTH-1:0]),
        .divisor (operand),
        .remNext (remNext),
        .quoNext (quoNext)
    );

    assign accNext = isDiv(opReg) ? {remNext, quoNext} : mulNext;
`else
    assign accNext = mulNext;
`endif

    // ---- sign fix-up and HI/LO write-back value ----
    always_comb begin
        prodS        = negRes ? -acc : acc;
        {hiNew, loNew} = {Hi, Lo};
        dzNew        = 1'b0;
        case (opReg)
            OP_MULT, OP_MULTU: {hiNew, loNew} = prodS;
            OP_MADD:           {hiNew, loNew} = {Hi, Lo} + prodS;
            OP_MSUB:           {hiNew, loNew} = {Hi, Lo} - prodS;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (bZero) begin
                    hiNew = aRaw;
                    loNew = '1;
                    dzNew = 1'b1;
                end else begin
                    // quotient truncates toward zero, remainder follows dividend
                    loNew = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    hiNew = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: ;
        endcase
    end

    // ---- datapath and architectural registers ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            opReg   <= OP_MULT;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            negRes  <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
`ifdef MDU_DIV_EN
            aRaw    <= '0;
            negRem  <= 1'b0;
            bZero   <= 1'b0;
`endif
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;

            // MTHI/MTLO (and disabled DIV/DIVU) finish at the issue edge
            if (issueShort) begin
                Done <= 1'b1;
                if (opIn == OP_MTHI) Hi <= A;
                if (opIn == OP_MTLO) Lo <= A;
            end

            if (issueLong) begin
                opReg  <= opIn;
                cnt    <= '0;
                negRes <= signA ^ signB;
`ifdef MDU_DIV_EN
                aRaw   <= A;
                negRem <= signA;
                bZero  <= (B == '0);
                if (isDiv(opIn)) begin
                    operand <= bMag;
                    acc     <= {{WIDTH{1'b0}}, aMag};
                end else
`endif
                begin
                    operand <= aMag;
                    acc     <= {{WIDTH{1'b0}}, bMag};
                end
            end

            if (state == S_CALC && !Flush) begin
                acc <= accNext;
                cnt <= cnt + CNT_W'(1);
            end

            if (state == S_FIX && !Flush) begin
                Hi      <= hiNew;
                Lo      <= loNew;
                Done    <= 1'b1;
                DivZero <= dzNew;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed bench for mdu_hilo (WIDTH = 32) with a transaction-level
// reference model compared every cycle, plus literal expectations from the test plan.
module tb_mdu_hilo;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Rst, Start, Flush;
    logic [2:0]    Op;
    logic [W-1:0]  A, B;
    logic          Busy, Done, DivZero;
    logic [W-1:0]  Hi, Lo;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 0;

    mdu_hilo #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Flush(Flush), .Op(Op),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .DivZero(DivZero),
        .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] mHi, mLo;
    logic         mBusy, mDone, mDz, pendDz;
    logic [63:0]  pend;
    int           left;

    function automatic bit isLong(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return op <= 3'd5;
`else
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5);
`endif
    endfunction

    // Result {Hi,Lo} of a multi-cycle op computed with plain wide arithmetic.
    function automatic void calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [63:0] hl, output logic [63:0] res, output logic dz);
        longint sa, sb, sp, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        dz = 1'b0;
        res = hl;
        case (op)
            3'd0: res = sp;
            3'd1: res = up;
            3'd4: res = hl + sp;
            3'd5: res = hl - sp;
            3'd2, 3'd3: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                    dz  = 1'b1;
                end else if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
            default: ;
        endcase
    endfunction

    always @(posedge Clk) begin
        mDone = 1'b0;
        mDz   = 1'b0;
        if (Rst) begin
            mHi = '0; mLo = '0; mBusy = 1'b0; left = 0;
        end else if (left > 0) begin
            if (Flush) begin
                left = 0; mBusy = 1'b0;
            end else begin
                left--;
                if (left == 0) begin
                    mBusy = 1'b0;
                    {mHi, mLo} = pend;
                    mDone = 1'b1;
                    mDz   = pendDz;
                end
            end
        end else if (Start && !Flush) begin
            if (isLong(Op)) begin
                calc(Op, A, B, {mHi, mLo}, pend, pendDz);
                left  = W + 1;
                mBusy = 1'b1;
            end else begin
                mDone = 1'b1;
                if (Op == 3'd6) mHi = A;
                if (Op == 3'd7) mLo = A;
            end
        end
    end

    always @(negedge Clk) begin
        if (chkEn) begin
            chk("busy",    Busy,    mBusy);
            chk("done",    Done,    mDone);
            chk("divzero", DivZero, mDz);
            chk("hi",      Hi,      mHi);
            chk("lo",      Lo,      mLo);
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge: presents the op so the next posedge issues it.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; A = $urandom; B = $urandom;
    endtask

    // n = 1 at the negedge following the issue edge.
    task automatic waitDone(input string nm, output int n);
        n = 1;
        while (!Done && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!Done) chk({nm, " timeout"}, 0, 1);
    endtask

    int n, doneCnt;

    initial begin
        Rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        chkEn = 1;
        chk("reset hi", Hi, 0);
        chk("reset lo", Lo, 0);
        chk("reset busy", Busy, 0);
        @(negedge Clk);

        // Test 1: MULT -3 * 5
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        chk("t1 busy first", Busy, 1);
        waitDone("t1", n);
        chk("t1 latency", n, 34);
        chk("t1 hi", Hi, 32'hFFFF_FFFF);
        chk("t1 lo", Lo, 32'hFFFF_FFF1);
        @(negedge Clk);

`ifdef MDU_DIV_EN
        // Test 2: DIV -7/2 then DIVU 7/0, back to back
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        waitDone("t2a", n);
        chk("t2 div lo", Lo, 32'hFFFF_FFFD);
        chk("t2 div hi", Hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd0);
        waitDone("t2b", n);
        chk("t2 dz latency", n, 34);
        chk("t2 dz lo", Lo, 32'hFFFF_FFFF);
        chk("t2 dz hi", Hi, 32'd7);
        chk("t2 dz flag", DivZero, 1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("t2c", n);
        chk("t2 ovf lo", Lo, 32'h8000_0000);
        chk("t2 ovf hi", Hi, 0);
        chk("t2 ovf flag", DivZero, 0);
        issue(3'd3, 32'hFFFF_FFF0, 32'd7);
        waitDone("t2d", n);
        issue(3'd2, 32'd100, 32'hFFFF_FFF9);
        waitDone("t2e", n);
        chk("t2 pos/neg lo", Lo, 32'hFFFF_FFF2);
        chk("t2 pos/neg hi", Hi, 32'd2);
        @(negedge Clk);
`endif

        // Test 3: MTHI, MTLO, MADD, MSUB
        issue(3'd6, 32'h10, 32'h0);
        chk("t3 mthi done", Done, 1);
        chk("t3 mthi busy", Busy, 0);
        issue(3'd7, 32'h20, 32'h0);
        chk("t3 mtlo done", Done, 1);
        issue(3'd4, 32'd3, 32'd4);
        waitDone("t3a", n);
        chk("t3 madd hi", Hi, 32'h10);
        chk("t3 madd lo", Lo, 32'h2C);
        issue(3'd5, 32'd1, 32'h2D);
        waitDone("t3b", n);
        chk("t3 msub hi", Hi, 32'hF);
        chk("t3 msub lo", Lo, 32'hFFFF_FFFF);
        // MTHI together with Flush must not write
        Flush = 1'b1;
        issue(3'd6, 32'hDEAD, 32'h0);
        Flush = 1'b0;
        chk("t3 flushed mthi hi", Hi, 32'hF);
        chk("t3 flushed mthi done", Done, 0);
        @(negedge Clk);

        // Test 4: MULTU flushed at cycle 10, then an immediate restart
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        chk("t4 busy after flush", Busy, 0);
        issue(3'd1, 32'd2, 32'd3);
        chk("t4 restart busy", Busy, 1);
        chk("t4 hold hi", Hi, 32'hF);
        chk("t4 hold lo", Lo, 32'hFFFF_FFFF);
        waitDone("t4", n);
        chk("t4 restart latency", n, 34);
        chk("t4 restart lo", Lo, 32'd6);
        chk("t4 restart hi", Hi, 32'd0);
        @(negedge Clk);

        // Test 5: reset mid-operation; Start during Busy is ignored
`ifdef MDU_DIV_EN
        issue(3'd2, 32'd100, 32'd7);
`else
        issue(3'd0, 32'd100, 32'd7);
`endif
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("t5 rst hi", Hi, 0);
        chk("t5 rst lo", Lo, 0);
        chk("t5 rst busy", Busy, 0);
        issue(3'd0, 32'd6, 32'd7);
        @(negedge Clk);
        issue(3'd6, 32'h55, 32'h0);
        doneCnt = 0;
        for (int i = 0; i < 2 * W + 10; i++) begin
            if (Done) doneCnt++;
            @(negedge Clk);
        end
        chk("t5 single done", doneCnt, 1);
        chk("t5 hi", Hi, 0);
        chk("t5 lo", Lo, 32'd42);

`ifndef MDU_DIV_EN
        // Test 6: DIV is a one-cycle no-op when the divider is not built
        issue(3'd2, 32'd9, 32'd3);
        chk("t6 done", Done, 1);
        chk("t6 busy", Busy, 0);
        chk("t6 dz", DivZero, 0);
        chk("t6 hi", Hi, 0);
        chk("t6 lo", Lo, 32'd42);
        @(negedge Clk);
`endif

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
